// File: rtl/rv32_multicycle_ctrl.sv
// rtl/rv32_multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for RV32I
//
// Optional feature macro: RV32_CTRL_RETIRE_CNT_EN (builds the retired-instruction counter;
// when undefined, retired is tied to 0).
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   i_instruction  IR contents, stable from the cycle after IRWrite
//   BrEq, BrLt     branch comparator results (BrLt signedness follows BrUn)
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request, held until mem_ready
//   MemRW          1 = write, 0 = read; meaningful while mem_req
//   PCWrite        PC load strobe
//   IRWrite        IR load strobe
//   PCSel          0 = PC+4, 1 = ALU result
//   ImmSel         0=I, 1=S, 2=B, 3=U, 4=J
//   BrUn           unsigned branch compare
//   ASel           0 = rs1, 1 = PC
//   BSel           0 = rs2, 1 = imm
//   ALUSel         0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 15 passB
//   RegWEn         register file write enable
//   WBSel          0 = mem, 1 = ALU, 2 = PC+4
//   trap           halted on illegal instruction / ECALL / EBREAK
//   state          0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP
//   retired        count of cycles with PCWrite=1 (retired instructions)
module rv32_multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instruction,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRW,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        PCSel,
  output logic [2:0]  ImmSel,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic [3:0]  ALUSel,
  output logic        RegWEn,
  output logic [1:0]  WBSel,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       legal;
  logic       taken;
  logic       is_branch, is_fence, is_load, is_store, is_jump;
  logic       pc_write_c, ir_write_c, reg_wen_c;
  logic       unused_ok;

  assign opcode    = i_instruction[6:0];
  assign rd        = i_instruction[11:7];
  assign funct3    = i_instruction[14:12];
  assign funct7    = i_instruction[31:25];
  assign unused_ok = ^i_instruction[24:15];

  assign is_branch = (opcode == OPC_BRANCH);
  assign is_fence  = (opcode == OPC_FENCE);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  // Shared funct3 -> ALU op map for OP and OP-IMM; bit30 only distinguishes SRL/SRA here,
  // SUB is handled by the caller because OP-IMM has no subtract.
  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic bit30);
    case (f3)
      3'b000:  f3_alu = 4'd0;
      3'b001:  f3_alu = 4'd2;
      3'b010:  f3_alu = 4'd3;
      3'b011:  f3_alu = 4'd4;
      3'b100:  f3_alu = 4'd5;
      3'b101:  f3_alu = bit30 ? 4'd7 : 4'd6;
      3'b110:  f3_alu = 4'd8;
      default: f3_alu = 4'd9;
    endcase
  endfunction

  // Instruction decode: datapath selects plus legality. SYSTEM (ECALL/EBREAK/CSR) falls
  // into the default arm and is therefore illegal, which sends DECODE to TRAP.
  always_comb begin
    legal  = 1'b0;
    ImmSel = IMM_I;
    ASel   = 1'b0;
    BSel   = 1'b0;
    ALUSel = ALU_ADD;
    BrUn   = 1'b0;
    WBSel  = WB_ALU;
    case (opcode)
      OPC_OP: begin
        legal  = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        ALUSel = f3_alu(funct3, i_instruction[30]);
        if ((funct3 == 3'b000) && i_instruction[30]) ALUSel = ALU_SUB;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        BSel   = 1'b1;
        ALUSel = f3_alu(funct3, i_instruction[30]);
      end
      OPC_LUI: begin
        legal  = 1'b1;
        BSel   = 1'b1;
        ImmSel = IMM_U;
        ALUSel = ALU_PASSB;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        ASel   = 1'b1;
        BSel   = 1'b1;
        ImmSel = IMM_U;
      end
      OPC_JAL: begin
        legal  = 1'b1;
        ASel   = 1'b1;
        BSel   = 1'b1;
        ImmSel = IMM_J;
        WBSel  = WB_PC4;
      end
      OPC_JALR: begin
        legal  = (funct3 == 3'b000);
        BSel   = 1'b1;
        WBSel  = WB_PC4;
      end
      OPC_BRANCH: begin
        legal  = (funct3[2:1] != 2'b01);
        ASel   = 1'b1;
        BSel   = 1'b1;
        ImmSel = IMM_B;
        BrUn   = funct3[1];
      end
      OPC_LOAD: begin
        legal  = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        BSel   = 1'b1;
        WBSel  = WB_MEM;
      end
      OPC_STORE: begin
        legal  = !funct3[2] && (funct3 != 3'b011);
        BSel   = 1'b1;
        ImmSel = IMM_S;
      end
      OPC_FENCE: legal = (funct3 == 3'b000);
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLt;
      3'b101, 3'b111: taken = !BrLt;
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= state_t'(RESET_STATE);
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    MemRW      = 1'b0;
    pc_write_c = 1'b0;
    ir_write_c = 1'b0;
    reg_wen_c  = 1'b0;
    PCSel      = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_branch) begin
          pc_write_c = 1'b1;
          PCSel      = taken;
          state_d    = S_FETCH;
        end else if (is_fence) begin
          pc_write_c = 1'b1;
          state_d    = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        MemRW   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_wen_c  = (rd != 5'd0);
        pc_write_c = 1'b1;
        PCSel      = is_jump;
        state_d    = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset abandons whatever instruction is in flight, so no architectural strobe may
  // fire in the reset cycle even if the FSM would otherwise complete a step.
  assign PCWrite = pc_write_c & ~rst;
  assign IRWrite = ir_write_c & ~rst;
  assign RegWEn  = reg_wen_c & ~rst;
  assign state   = state_q;

`ifdef RV32_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst)          retired_q <= 32'd0;
    else if (PCWrite) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb/tb_rv32_multicycle_ctrl.sv - self-checking bench for rv32_multicycle_ctrl
module tb_rv32_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_instruction;
  logic        BrEq, BrLt, mem_ready;
  logic        mem_req, MemRW, PCWrite, IRWrite, PCSel, BrUn, ASel, BSel, RegWEn, trap;
  logic [2:0]  ImmSel, state;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel;
  logic [31:0] retired;

  always #5 clk = ~clk;

  rv32_multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
    .clk(clk), .rst(rst), .i_instruction(i_instruction), .BrEq(BrEq), .BrLt(BrLt),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemRW(MemRW), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .PCSel(PCSel), .ImmSel(ImmSel), .BrUn(BrUn), .ASel(ASel),
    .BSel(BSel), .ALUSel(ALUSel), .RegWEn(RegWEn), .WBSel(WBSel), .trap(trap),
    .state(state), .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] retire_model = 32'd0;

  typedef enum int {K_ILL, K_ALU, K_LOAD, K_STORE, K_BR, K_FENCE, K_JUMP} klass_t;

  // Expected per-cycle view: state and the strobes, with MemRW shown only under mem_req
  // and PCSel only under PCWrite.
  typedef struct packed {
    logic [2:0]  st;
    logic        req, rw, pcw, irw, rwe, pcs, trp;
    logic [31:0] ret;
  } obs_t;

  typedef struct packed {
    obs_t exp;
    logic rdy;
  } rec_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st, input logic [6:0] f);
    obs_t o;
    o = '0;
    o.st = st;
    {o.req, o.rw, o.pcw, o.irw, o.rwe, o.pcs, o.trp} = f;
    return o;
  endfunction

  function automatic rec_t rc(input obs_t e, input logic rdy);
    rec_t r;
    r.exp = e;
    r.rdy = rdy;
    return r;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st  = state;
    o.req = mem_req;
    o.rw  = mem_req & MemRW;
    o.pcw = PCWrite;
    o.irw = IRWrite;
    o.rwe = RegWEn;
    o.pcs = PCWrite & PCSel;
    o.trp = trap;
    o.ret = retired;
    return o;
  endfunction

  // Instruction classes straight from the RV32I base encoding tables.
  function automatic klass_t classify(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_ALU : K_ILL;
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? K_ALU : K_ILL;
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? K_ALU : K_ILL;
        return K_ALU;
      end
      7'h37, 7'h17: return K_ALU;
      7'h6f: return K_JUMP;
      7'h67: return (f3 == 3'd0) ? K_JUMP : K_ILL;
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? K_LOAD : K_ILL;
      7'h23: return (f3 inside {3'd0, 3'd1, 3'd2}) ? K_STORE : K_ILL;
      7'h63: return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7}) ? K_BR : K_ILL;
      7'h0f: return (f3 == 3'd0) ? K_FENCE : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  // add,sll,slt,sltu,xor,srl,or,and map onto 0,2,3,4,5,6,8,9.
  function automatic logic [3:0] alu_for(input logic [2:0] f3, input logic bit30, input logic is_op);
    logic [3:0] v;
    if (f3 == 3'd0)      v = (is_op && bit30) ? 4'd1 : 4'd0;
    else if (f3 <= 3'd5) v = {1'b0, f3} + 4'd1;
    else                 v = {1'b0, f3} + 4'd2;
    if (f3 == 3'd5 && bit30) v = 4'd7;
    return v;
  endfunction

  function automatic logic [11:0] exp_fields(input logic [31:0] ins);
    logic [2:0] f3, imm;
    logic       a, b, brun;
    logic [3:0] alu;
    logic [1:0] wb;
    f3 = ins[14:12]; imm = 3'd0; a = 1'b0; b = 1'b1; brun = 1'b0; alu = 4'd0; wb = 2'd1;
    case (ins[6:0])
      7'h33: begin b = 1'b0; alu = alu_for(f3, ins[30], 1'b1); end
      7'h13: alu = alu_for(f3, ins[30], 1'b0);
      7'h37: begin imm = 3'd3; alu = 4'd15; end
      7'h17: begin imm = 3'd3; a = 1'b1; end
      7'h6f: begin imm = 3'd4; a = 1'b1; wb = 2'd2; end
      7'h67: wb = 2'd2;
      7'h03: wb = 2'd0;
      7'h23: imm = 3'd1;
      7'h63: begin imm = 3'd2; a = 1'b1; brun = f3[1]; end
      default: ;
    endcase
    return {imm, a, b, alu, brun, wb};
  endfunction

  // ImmSel has no meaning for R-type, BrUn only for branches.
  function automatic logic [11:0] fmask(input logic [31:0] ins);
    return {(ins[6:0] == 7'h33) ? 3'b000 : 3'b111, 6'h3F, (ins[6:0] == 7'h63), 2'b11};
  endfunction

  function automatic logic [11:0] sample_fields();
    return {ImmSel, ASel, BSel, ALUSel, BrUn, WBSel};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 10))
      0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h37;  3: opc = 7'h17;
      4: opc = 7'h6f;  5: opc = 7'h67;  6: opc = 7'h03;  7: opc = 7'h23;
      8: opc = 7'h63;  9: opc = 7'h0f;  default: opc = r[6:0];
    endcase
    r[6:0] = opc;
    if ($urandom_range(0, 3) != 0) begin
      if (opc == 7'h33) r[31:25] = r[30] ? 7'h20 : 7'h00;
      if (opc == 7'h13 && r[13:12] == 2'b01) r[31:25] = (r[14] && r[30]) ? 7'h20 : 7'h00;
      if (opc == 7'h67 || opc == 7'h0f) r[14:12] = 3'b000;
    end
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Builds the expected cycle trace of one instruction from its class, then replays it
  // against the DUT. Entered and left at posedge+1 with the DUT in FETCH (or TRAP).
  task automatic run(input string name, input logic [31:0] ins, input int fs, input int ms,
                     input int ntrap, input logic eq, input logic lt);
    rec_t       tr[$];
    klass_t     k;
    logic [2:0] f3;
    logic       taken, st;
    obs_t       e;
    logic [11:0] m;
    k  = classify(ins);
    f3 = ins[14:12];
    st = (k == K_STORE);
    taken = (f3 == 3'd0) ? eq : (f3 == 3'd1) ? !eq : (f3[0] == 1'b0) ? lt : !lt;
    for (int i = 0; i < fs; i++) tr.push_back(rc(mk(3'd0, 7'b1000000), 1'b0));
    tr.push_back(rc(mk(3'd0, 7'b1001000), 1'b1));
    tr.push_back(rc(mk(3'd1, 7'b0000000), rbit()));
    if (k == K_ILL) begin
      for (int i = 0; i < ntrap; i++) tr.push_back(rc(mk(3'd5, 7'b0000001), rbit()));
    end else begin
      if (k == K_BR)         tr.push_back(rc(mk(3'd2, {4'b0010, 1'b0, taken, 1'b0}), rbit()));
      else if (k == K_FENCE) tr.push_back(rc(mk(3'd2, 7'b0010000), rbit()));
      else                   tr.push_back(rc(mk(3'd2, 7'b0000000), rbit()));
      if (k == K_LOAD || k == K_STORE) begin
        for (int i = 0; i < ms; i++) tr.push_back(rc(mk(3'd3, {1'b1, st, 5'b00000}), 1'b0));
        tr.push_back(rc(mk(3'd3, {1'b1, st, st, 4'b0000}), 1'b1));
      end
      if (k == K_ALU || k == K_LOAD || k == K_JUMP)
        tr.push_back(rc(mk(3'd4, {4'b0010, (ins[11:7] != 5'd0), (k == K_JUMP), 1'b0}), rbit()));
    end
    i_instruction = ins;
    BrEq = eq;
    BrLt = lt;
    foreach (tr[j]) begin
      mem_ready = tr[j].rdy;
      #2;
      e = tr[j].exp;
`ifdef RV32_CTRL_RETIRE_CNT_EN
      e.ret = retire_model;
`else
      e.ret = 32'd0;
`endif
      check($sformatf("%s/c%0d", name, j), 64'(sample()), 64'(e));
      if (k != K_ILL && k != K_FENCE && e.st inside {3'd2, 3'd3, 3'd4}) begin
        m = fmask(ins);
        check($sformatf("%s/f%0d", name, j), 64'(sample_fields() & m), 64'(exp_fields(ins) & m));
      end
      if (e.pcw) retire_model = retire_model + 32'd1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    #2;
    check("rst_cycle_strobes", 64'({PCWrite, IRWrite, RegWEn}), 64'(3'b000));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    retire_model = 32'd0;
    #1;
    check("rst_state", 64'({state, mem_req, trap, PCWrite, IRWrite, RegWEn}),
          64'({3'd0, 1'b1, 1'b0, 3'b000}));
    check("rst_retired", 64'(retired), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    rst = 1'b1;
    i_instruction = 32'd0;
    BrEq = 1'b0;
    BrLt = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run("addi", 32'h00500093, 0, 0, 0, 1'b0, 1'b0);
    run("lw_stall", 32'h0000A103, 0, 2, 0, 1'b0, 1'b0);
    run("sw", 32'h0020A223, 0, 0, 0, 1'b0, 1'b0);
    run("beq_taken", 32'h00108463, 0, 0, 0, 1'b1, 1'b0);
    run("beq_not", 32'h00108463, 0, 0, 0, 1'b0, 1'b0);
    run("fetch_stall", 32'h00500093, 3, 0, 0, 1'b0, 1'b0);

    run("illegal", 32'hFFFFFFFF, 0, 0, 10, 1'b0, 1'b0);
    do_reset();
    run("ecall", 32'h00000073, 0, 0, 10, 1'b0, 1'b0);
    do_reset();

    for (int n = 0; n < 3; n++) run($sformatf("addi3_%0d", n), 32'h00500093, 0, 0, 0, 1'b0, 1'b0);
`ifdef RV32_CTRL_RETIRE_CNT_EN
    check("retired_after_3", 64'(retired), 64'd3);
`else
    check("retired_after_3", 64'(retired), 64'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      ins = rand_instr();
      run($sformatf("rnd%0d", n), ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
          3, rbit(), rbit());
      if (classify(ins) == K_ILL) do_reset();
    end

    // Reset while a store is in MEM with mem_ready high: the PC strobe must not fire.
    i_instruction = 32'h0020A223;
    for (int s = 0; s < 3; s++) begin
      mem_ready = (s == 0);
      #2;
      check($sformatf("st_pre%0d", s), 64'(state), 64'(s));
      @(posedge clk);
      #1;
    end
    check("st_in_mem", 64'(state), 64'd3);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
